// File: rtl/cache_port_arbiter_if.sv
// cache_port_arbiter_if: requester-side and cache-controller-side signals of the shared cache port.
interface cache_port_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 10
);
  logic          req0, req1, rw0, rw1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic          cc_valid, cc_rw;
  logic [AW-1:0] cc_addr;
  logic [DW-1:0] cc_wdata;
  logic          cc_done;
  logic [DW-1:0] cc_rdata;
  logic          busy;
  modport slave (
    input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, cc_done, cc_rdata,
    output ack0, ack1, err0, err1, rdata0, rdata1, cc_valid, cc_rw, cc_addr, cc_wdata, busy
  );
  modport master (
    output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, cc_done, cc_rdata,
    input  ack0, ack1, err0, err1, rdata0, rdata1, cc_valid, cc_rw, cc_addr, cc_wdata, busy
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: round-robin sharing of one cache controller port between fetch (0) and load/store (1).
module cache_port_arbiter #(
  parameter int AW      = 10,
  parameter int DW      = 10,
  parameter int TIMEOUT = 15
) (
  input logic                 clk,
  input logic                 rst_n,
  cache_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);
  state_e        state_q, state_d;
  logic          gnt_q, gnt_d, last_q, last_d, err_q, err_d, rw_q, rw_d, win, resp_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d, rdata0_q, rdata1_q;
  logic [3:0]    tmo_q, tmo_d;
  logic          valid_q, ack0_q, ack1_q, err0_q, err1_q;
  // on a tie the port that did not win last time goes next
  assign win = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (bus.req0 || bus.req1) begin
        gnt_d   = win;
        last_d  = win;
        rw_d    = win ? bus.rw1 : bus.rw0;
        addr_d  = win ? bus.addr1 : bus.addr0;
        wdata_d = win ? bus.wdata1 : bus.wdata0;
        state_d = ISSUE;
      end
      ISSUE: begin
        tmo_d   = '0;
        err_d   = 1'b0;
        state_d = WAIT;
      end
      WAIT: if (bus.cc_done) begin
        rdata_d = bus.cc_rdata;
        state_d = RESP;
      end else if (tmo_q == TMO_LAST) begin
        err_d   = 1'b1;
        rdata_d = '0;
        state_d = RESP;
      end else begin
        tmo_d = tmo_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign resp_d = state_d == RESP;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end
  // outputs are registered from next-state values so they line up with the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      valid_q  <= state_d == ISSUE;
      ack0_q   <= resp_d && !gnt_q;
      ack1_q   <= resp_d && gnt_q;
      err0_q   <= resp_d && !gnt_q && err_d;
      err1_q   <= resp_d && gnt_q && err_d;
      rdata0_q <= (resp_d && !gnt_q) ? rdata_d : '0;
      rdata1_q <= (resp_d && gnt_q) ? rdata_d : '0;
    end
  end
  assign bus.cc_valid = valid_q;
  assign bus.cc_rw    = rw_q;
  assign bus.cc_addr  = addr_q;
  assign bus.cc_wdata = wdata_q;
  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.err0     = err0_q;
  assign bus.err1     = err1_q;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
  assign bus.busy     = state_q != IDLE;
endmodule
